noc_flit_injector: RTL and testbench
====================================

NOC_FLIT_INJECTOR -- requirements
Module: noc_flit_injector

Interface
REQ-001 SHALL have parameter NUM_VCS, default 2, virtual channels on the send port (VC_BITS = clog2(NUM_VCS), minimum 1).
REQ-002 SHALL have parameter DEST_BITS, default 5, destination field width (25-node network).
REQ-003 SHALL have parameter DATA_W, default 32, flit payload width.
REQ-004 SHALL have parameter BUF_DEPTH, default 4, downstream flit buffers per VC (initial credits).
REQ-005 SHALL have parameter PKT_LEN, default 4, flits per packet (minimum 1).
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, power of two, source word queue depth.
REQ-007 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-008 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port src_valid  input  1  source word offered.
REQ-010 SHALL have port src_ready  output  1  word accepted when src_valid and src_ready are both high.
REQ-011 SHALL have port src_data  input  DATA_W  payload word.
REQ-012 SHALL have port src_dest  input  DEST_BITS  destination node; used only from the packet's head word.
REQ-013 SHALL have port flit_out  output  FLIT_W = 2+DEST_BITS+VC_BITS+DATA_W  {valid, tail, dest, vc, data}, MSB first.
REQ-014 SHALL have port flit_out_en  output  1  network putFlit enable.
REQ-015 SHALL have port credit_in  input  1+VC_BITS  {valid, vc} credit return from the network.
REQ-016 SHALL have port busy  output  1  high when FSM is not IDLE or the FIFO is non-empty.
REQ-017 SHALL have port credit_err  output  1  sticky credit-overflow flag.

Function
REQ-018 SHALL buffer {src_dest, src_data} in a FIFO; src_ready = not full; no push when full, even if a pop occurs that cycle.
REQ-019 SHALL keep one credit counter per VC, width clog2(BUF_DEPTH+1), reset to BUF_DEPTH.
REQ-020 SHALL use FSM states IDLE and SEND.
REQ-021 IDLE: if FIFO non-empty and some VC has credit > 0, SHALL select the first such VC searching from rr_ptr upward (wrapping), latch it and head dest, and issue the head flit that cycle.
REQ-022 IDLE: SHALL go to SEND after the head flit issues unless PKT_LEN = 1; otherwise SHALL remain in IDLE.
REQ-023 SEND: SHALL issue one flit per cycle when FIFO non-empty and credit[latched vc] > 0, else stall with flit_out_en = 0.
REQ-024 Each flit SHALL carry the latched dest and vc; valid bit = 1; tail = 1 only on flit PKT_LEN of the packet.
REQ-025 After the tail issues, SHALL return to IDLE and set rr_ptr = (vc+1) mod NUM_VCS.
REQ-026 flit_out and flit_out_en SHALL be registered; flit_out_en is high exactly one cycle per flit; flit_out = 0 when flit_out_en = 0.
REQ-027 Latency: word accepted in cycle N with FSM IDLE, credit available, and FIFO empty SHALL appear on flit_out in cycle N+2; back-to-back flits SHALL leave on consecutive cycles.
REQ-028 Issue SHALL decrement credit[vc]; credit_in valid SHALL increment credit[credit_in.vc]; both events on the same VC in one cycle SHALL leave it unchanged.
REQ-029 Increment at BUF_DEPTH without same-cycle decrement SHALL saturate the counter and set credit_err until reset.
REQ-030 credit_in with vc >= NUM_VCS SHALL be ignored and SHALL set credit_err.

Reset
REQ-031 While RST_N = 0: FSM IDLE, FIFO empty, rr_ptr = 0, credits = BUF_DEPTH, flit_out = 0, flit_out_en = 0, src_ready = 0, busy = 0, credit_err = 0.
REQ-032 Reset mid-packet SHALL discard the partial packet and queued words; no tail is emitted.
REQ-033 src_ready SHALL rise in the first cycle after RST_N deasserts.

Verification
REQ-034 Reset: RST_N low for 2 cycles -> flit_out_en = 0 and src_ready = 0 throughout; after release src_ready = 1, credit_err = 0.
REQ-035 Single packet: push data 1..4 with dest = 7 back-to-back from cycle 3 -> flits in cycles 5..8, vc = 0, dest = 7, tail only in cycle 8.
REQ-036 Credit exhaustion: push 12 words, no credit returns -> packet 0 on VC0, packet 1 on VC1, third head stalls; return {1,0} -> exactly one flit on VC0 two cycles later, then stall.
REQ-037 Simultaneous events: issue on VC0 and return a VC0 credit in the same cycle -> credit[0] unchanged; FIFO full with pop -> src_ready stays 0 that cycle.
REQ-038 Overflow: credit_in = {1,1} with credit[1] = 4 -> credit[1] stays 4, credit_err = 1 until next reset.
REQ-039 Mid-packet reset: assert RST_N after flit 2 of 4 -> no further flits; busy = 0; a new packet afterwards starts on VC0 with full credits.

Source files
------------

// File: rtl/noc_flit_injector.sv
// Generic synchronous FIFO used for the injector's source word queue.
// Latency: a pushed word is visible at the head one cycle later.
// Backpressure: push_rdy is low when full; a same-cycle pop does not free a slot.
module fifo_sync #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign push_rdy = (count != (AW+1)'(DEPTH));
  assign pop_vld  = (count != '0);
  assign push     = push_vld && push_rdy;
  assign pop      = pop_rdy && pop_vld;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge core_clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

// Packetising NoC injector: queues source words, picks a VC round-robin, sends PKT_LEN-flit packets.
// Latency: word accepted in cycle N leaves on flit_out in cycle N+2; one flit per cycle thereafter.
// Backpressure: src_ready follows FIFO space; flits stall while the packet's VC has no credit.
module noc_flit_injector #(
  parameter int NUM_VCS    = 2,
  parameter int DEST_BITS  = 5,
  parameter int DATA_W     = 32,
  parameter int BUF_DEPTH  = 4,
  parameter int PKT_LEN    = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int VC_BITS   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int FLIT_W    = 2 + DEST_BITS + VC_BITS + DATA_W
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [DATA_W-1:0]    src_data,
  input  logic [DEST_BITS-1:0] src_dest,
  output logic [FLIT_W-1:0]    flit_out,
  output logic                 flit_out_en,
  input  logic [VC_BITS:0]     credit_in,
  output logic                 busy,
  output logic                 credit_err
);
  localparam int CRED_W = $clog2(BUF_DEPTH + 1);
  localparam int CNT_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [DEST_BITS-1:0] dest;
    logic [DATA_W-1:0]    dat;
  } word_t;

  typedef struct packed {
    logic                 vld;
    logic                 tail;
    logic [DEST_BITS-1:0] dest;
    logic [VC_BITS-1:0]   vc;
    logic [DATA_W-1:0]    dat;
  } flit_t;

  state_t               state_q, state_d;
  logic [VC_BITS-1:0]   vc_q, rr_q, sel_vc, issue_vc, rr_next, cr_vc;
  logic [DEST_BITS-1:0] dest_q, issue_dest;
  logic [CNT_W-1:0]     cnt_q;
  logic [CRED_W-1:0]    credit_q [NUM_VCS];
  logic [NUM_VCS-1:0]   inc_v, dec_v;
  logic [VC_BITS:0]     cand;
  logic                 rdy_en_q, fifo_vld, fifo_rdy, sel_found;
  logic                 issue, issue_tail, cr_vld, cr_bad, cr_hit, ovf;
  word_t                push_word, head;
  flit_t                flit_d;

  assign push_word = '{dest: src_dest, dat: src_data};
  assign src_ready = fifo_rdy && rdy_en_q;
  assign busy      = (state_q != IDLE) || fifo_vld;

  fifo_sync #(.W($bits(word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .core_clk (CLK),
    .arst_n   (RST_N),
    .push_vld (src_valid && rdy_en_q),
    .push_rdy (fifo_rdy),
    .push_dat (push_word),
    .pop_vld  (fifo_vld),
    .pop_rdy  (issue),
    .pop_dat  (head)
  );

  // First VC with credit, searching upward from rr_q with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_vc    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      cand = {1'b0, rr_q} + (VC_BITS+1)'(i);
      if (cand >= (VC_BITS+1)'(NUM_VCS)) cand = cand - (VC_BITS+1)'(NUM_VCS);
      if (!sel_found && credit_q[cand[VC_BITS-1:0]] != '0) begin
        sel_found = 1'b1;
        sel_vc    = cand[VC_BITS-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_vc   = vc_q;
    issue_dest = dest_q;
    issue_tail = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_vld && sel_found) begin
          issue      = 1'b1;
          issue_vc   = sel_vc;
          issue_dest = head.dest;
          issue_tail = (PKT_LEN == 1);
          state_d    = (PKT_LEN == 1) ? IDLE : SEND;
        end
      end
      SEND: begin
        if (fifo_vld && credit_q[vc_q] != '0) begin
          issue      = 1'b1;
          issue_tail = (cnt_q == CNT_W'(PKT_LEN - 1));
          if (issue_tail) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flit_d.vld  = 1'b1;
    flit_d.tail = issue_tail;
    flit_d.dest = issue_dest;
    flit_d.vc   = issue_vc;
    flit_d.dat  = head.dat;
  end

  assign rr_next = (issue_vc == VC_BITS'(NUM_VCS - 1)) ? '0 : issue_vc + VC_BITS'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vc_q        <= '0;
      dest_q      <= '0;
      cnt_q       <= '0;
      rr_q        <= '0;
      rdy_en_q    <= 1'b0;
      flit_out    <= '0;
      flit_out_en <= 1'b0;
    end else begin
      rdy_en_q    <= 1'b1;
      flit_out_en <= issue;
      flit_out    <= issue ? flit_d : '0;
      if (issue) begin
        if (state_q == IDLE) begin
          vc_q   <= issue_vc;
          dest_q <= issue_dest;
          cnt_q  <= CNT_W'(1);
        end else begin
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        if (issue_tail) rr_q <= rr_next;
      end
    end
  end

  // Out-of-range VC returns are dropped but flagged like an overflow.
  assign cr_vld = credit_in[VC_BITS];
  assign cr_vc  = credit_in[VC_BITS-1:0];
  assign cr_bad = cr_vld && ({1'b0, cr_vc} >= (VC_BITS+1)'(NUM_VCS));
  assign cr_hit = cr_vld && !cr_bad;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    ovf   = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      inc_v[v] = cr_hit && (cr_vc == VC_BITS'(v));
      dec_v[v] = issue && (issue_vc == VC_BITS'(v));
      if (inc_v[v] && !dec_v[v] && credit_q[v] == CRED_MAX) ovf = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (inc_v[v] && !dec_v[v] && credit_q[v] != CRED_MAX)
          credit_q[v] <= credit_q[v] + CRED_W'(1);
        else if (dec_v[v] && !inc_v[v])
          credit_q[v] <= credit_q[v] - CRED_W'(1);
      end
      credit_err <= credit_err | ovf | cr_bad;
    end
  end
endmodule

// File: tb/tb_noc_flit_injector.sv
// Bench for noc_flit_injector: directed tables and sequences plus random traffic against a packet-level model.
module tb_noc_flit_injector;
  localparam int NUM_VCS    = 2;
  localparam int DEST_BITS  = 5;
  localparam int DATA_W     = 32;
  localparam int BUF_DEPTH  = 4;
  localparam int PKT_LEN    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int VC_BITS    = 1;
  localparam int FLIT_W     = 2 + DEST_BITS + VC_BITS + DATA_W;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic                 src_valid;
  logic                 src_ready;
  logic [DATA_W-1:0]    src_data;
  logic [DEST_BITS-1:0] src_dest;
  logic [FLIT_W-1:0]    flit_out;
  logic                 flit_out_en;
  logic [VC_BITS:0]     credit_in;
  logic                 busy;
  logic                 credit_err;

  noc_flit_injector #(
    .NUM_VCS(NUM_VCS), .DEST_BITS(DEST_BITS), .DATA_W(DATA_W),
    .BUF_DEPTH(BUF_DEPTH), .PKT_LEN(PKT_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .src_dest(src_dest), .flit_out(flit_out),
    .flit_out_en(flit_out_en), .credit_in(credit_in), .busy(busy),
    .credit_err(credit_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: words in order, packets of PKT_LEN, per-VC credit pools, round-robin VC choice.
  typedef struct {
    logic [DEST_BITS-1:0] dest;
    logic [DATA_W-1:0]    data;
  } word_t;

  word_t                m_q[$];
  int                   m_cred[NUM_VCS];
  int                   m_pos, m_rr, m_cur_vc;
  logic [DEST_BITS-1:0] m_cur_dest;
  bit                   m_err;

  bit                obs_en, obs_ready;
  logic [FLIT_W-1:0] obs_flit;
  int                n_flits;
  int                vc_cnt[NUM_VCS];

  task automatic model_reset();
    m_q.delete();
    for (int v = 0; v < NUM_VCS; v++) m_cred[v] = BUF_DEPTH;
    m_pos = 0; m_rr = 0; m_cur_vc = 0; m_cur_dest = '0; m_err = 1'b0;
  endtask

  function automatic int obs_vc();
    return int'(obs_flit[DATA_W +: VC_BITS]);
  endfunction

  // Called just after a falling edge; drives one cycle and checks against the model.
  task automatic cyc(input bit vld, input logic [DEST_BITS-1:0] dst, input logic [DATA_W-1:0] dat,
                     input bit cr_vld, input int cr_vc);
    bit                exp_ready, found, tail, exp_en;
    int                vsel;
    word_t             w;
    logic [FLIT_W-1:0] exp_flit;
    src_valid = vld; src_dest = dst; src_data = dat;
    credit_in = {cr_vld, VC_BITS'(cr_vc)};
    #1;
    exp_ready = (m_q.size() < FIFO_DEPTH);
    obs_ready = src_ready;
    chk("src_ready", 64'(src_ready), 64'(exp_ready));
    found = 1'b0; vsel = 0; exp_en = 1'b0; exp_flit = '0;
    if (m_q.size() > 0) begin
      if (m_pos == 0) begin
        for (int i = 0; i < NUM_VCS; i++) begin
          int v;
          v = (m_rr + i) % NUM_VCS;
          if (!found && m_cred[v] > 0) begin found = 1'b1; vsel = v; end
        end
      end else if (m_cred[m_cur_vc] > 0) begin
        found = 1'b1; vsel = m_cur_vc;
      end
    end
    if (found) begin
      w = m_q.pop_front();
      if (m_pos == 0) begin m_cur_vc = vsel; m_cur_dest = w.dest; end
      tail = (m_pos == PKT_LEN - 1);
      exp_en = 1'b1;
      exp_flit = {1'b1, tail, m_cur_dest, VC_BITS'(vsel), w.data};
      m_cred[vsel]--;
      m_pos = tail ? 0 : m_pos + 1;
      if (tail) m_rr = (vsel + 1) % NUM_VCS;
    end
    if (cr_vld) begin
      if (cr_vc < NUM_VCS) begin
        if (m_cred[cr_vc] >= BUF_DEPTH) m_err = 1'b1;
        else m_cred[cr_vc]++;
      end else m_err = 1'b1;
    end
    if (vld && exp_ready) m_q.push_back('{dst, dat});
    @(posedge CLK); #1;
    obs_en = flit_out_en; obs_flit = flit_out;
    if (flit_out_en) begin n_flits++; vc_cnt[obs_vc()]++; end
    chk("flit_out_en", 64'(flit_out_en), 64'(exp_en));
    chk("flit_out", 64'(flit_out), 64'(exp_flit));
    chk("busy", 64'(busy), 64'((m_pos != 0) || (m_q.size() != 0)));
    chk("credit_err", 64'(credit_err), 64'(m_err));
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, '0, 1'b0, 0);
  endtask

  task automatic clr_cnt();
    n_flits = 0;
    for (int v = 0; v < NUM_VCS; v++) vc_cnt[v] = 0;
  endtask

  task automatic reset_dut();
    RST_N = 1'b0; src_valid = 1'b0; src_data = '0; src_dest = '0; credit_in = '0;
    #1;
    chk("rst_async_en", 64'(flit_out_en), 64'(0));
    chk("rst_async_busy", 64'(busy), 64'(0));
    repeat (2) begin
      @(posedge CLK); #1;
      chk("rst_en", 64'(flit_out_en), 64'(0));
      chk("rst_flit", 64'(flit_out), 64'(0));
      chk("rst_src_ready", 64'(src_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_credit_err", 64'(credit_err), 64'(0));
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rel_src_ready", 64'(src_ready), 64'(1));
    chk("rel_credit_err", 64'(credit_err), 64'(0));
    chk("rel_en", 64'(flit_out_en), 64'(0));
    @(negedge CLK);
    model_reset();
  endtask

  typedef struct {
    bit                vld;
    logic [DATA_W-1:0] data;
    bit                exp_en;
    bit                exp_tail;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    tbl[0] = '{1'b1, 32'd1, 1'b0, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 32'd2, 1'b1, 1'b0, 32'd1};
    tbl[2] = '{1'b1, 32'd3, 1'b1, 1'b0, 32'd2};
    tbl[3] = '{1'b1, 32'd4, 1'b1, 1'b0, 32'd3};
    tbl[4] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd4};
    tbl[5] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0};

    RST_N = 1'b1; src_valid = 1'b0; src_data = '0; src_dest = '0; credit_in = '0;
    model_reset(); clr_cnt();
    #2;
    reset_dut();

    // Single packet to dest 7 on VC0.
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].vld, DEST_BITS'(7), tbl[i].data, 1'b0, 0);
      chk($sformatf("pkt_en[%0d]", i), 64'(obs_en), 64'(tbl[i].exp_en));
      if (tbl[i].exp_en) begin
        chk($sformatf("pkt_tail[%0d]", i), 64'(obs_flit[FLIT_W-2]), 64'(tbl[i].exp_tail));
        chk($sformatf("pkt_data[%0d]", i), 64'(obs_flit[DATA_W-1:0]), 64'(tbl[i].exp_data));
        chk($sformatf("pkt_dest[%0d]", i), 64'(obs_flit[DATA_W+VC_BITS +: DEST_BITS]), 64'(7));
        chk($sformatf("pkt_vc[%0d]", i), 64'(obs_vc()), 64'(0));
      end
    end

    // Overflow on VC1 at full credit: flag sticks, counter must stay at BUF_DEPTH.
    cyc(1'b0, '0, '0, 1'b1, 1);
    chk("ovf_err", 64'(credit_err), 64'(1));
    clr_cnt();
    for (int i = 0; i < 5; i++) cyc(1'b1, DEST_BITS'(3), 32'h50 + 32'(i), 1'b0, 0);
    idle(8);
    chk("ovf_vc1_flits", 64'(vc_cnt[1]), 64'(4));
    chk("ovf_total_flits", 64'(n_flits), 64'(4));
    chk("ovf_sticky", 64'(credit_err), 64'(1));

    // Credit exhaustion across both VCs.
    reset_dut();
    clr_cnt();
    pushed = 0;
    for (int k = 0; k < 60 && pushed < 12; k++) begin
      cyc(1'b1, DEST_BITS'(k % 25), 32'h100 + 32'(pushed), 1'b0, 0);
      if (obs_ready) pushed++;
    end
    chk("exh_pushed", 64'(pushed), 64'(12));
    idle(20);
    chk("exh_vc0", 64'(vc_cnt[0]), 64'(4));
    chk("exh_vc1", 64'(vc_cnt[1]), 64'(4));
    chk("exh_busy", 64'(busy), 64'(1));
    cyc(1'b0, '0, '0, 1'b1, 0);
    chk("ret_not_yet", 64'(obs_en), 64'(0));
    idle(1);
    chk("ret_flit", 64'(obs_en), 64'(1));
    chk("ret_flit_vc", 64'(obs_vc()), 64'(0));
    clr_cnt();
    idle(5);
    chk("ret_stall", 64'(n_flits), 64'(0));

    // Issue and return on VC0 in the same cycle keeps the count.
    cyc(1'b0, '0, '0, 1'b1, 0);
    cyc(1'b0, '0, '0, 1'b1, 0);
    chk("sim_issue", 64'(obs_en), 64'(1));
    idle(1);
    chk("sim_credit_kept", 64'(obs_en), 64'(1));
    clr_cnt();
    idle(4);
    chk("sim_stall", 64'(n_flits), 64'(0));

    // Fill the FIFO, then pop while full with a word offered.
    for (int j = 0; j < 7; j++) cyc(1'b1, DEST_BITS'(5), 32'h300 + 32'(j), 1'b0, 0);
    cyc(1'b1, DEST_BITS'(5), 32'h3AA, 1'b1, 0);
    chk("full_ready", 64'(obs_ready), 64'(0));
    cyc(1'b1, DEST_BITS'(5), 32'h3AB, 1'b0, 0);
    chk("full_pop_ready", 64'(obs_ready), 64'(0));
    chk("full_pop_issue", 64'(obs_en), 64'(1));
    cyc(1'b1, DEST_BITS'(5), 32'h3AC, 1'b0, 0);
    chk("after_pop_ready", 64'(obs_ready), 64'(1));
    idle(2);

    // Reset in the middle of a packet.
    reset_dut();
    cyc(1'b1, DEST_BITS'(9), 32'h200, 1'b0, 0);
    cyc(1'b1, DEST_BITS'(9), 32'h201, 1'b0, 0);
    cyc(1'b1, DEST_BITS'(9), 32'h202, 1'b0, 0);
    chk("mid_flit2", 64'(obs_en), 64'(1));
    reset_dut();
    clr_cnt();
    idle(3);
    chk("mid_no_flits", 64'(n_flits), 64'(0));
    cyc(1'b1, DEST_BITS'(11), 32'h400, 1'b0, 0);
    cyc(1'b1, DEST_BITS'(11), 32'h401, 1'b0, 0);
    chk("mid_new_en", 64'(obs_en), 64'(1));
    chk("mid_new_vc", 64'(obs_vc()), 64'(0));
    cyc(1'b1, DEST_BITS'(11), 32'h402, 1'b0, 0);
    cyc(1'b1, DEST_BITS'(11), 32'h403, 1'b0, 0);
    idle(4);
    chk("mid_new_flits", 64'(n_flits), 64'(4));

    // Random traffic with a well-behaved network returning credits.
    reset_dut();
    for (int blk = 0; blk < 6; blk++) begin
      int p_push, p_ret;
      p_push = int'($urandom_range(20, 95));
      p_ret  = int'($urandom_range(10, 90));
      for (int t = 0; t < 500; t++) begin
        int  crv;
        bit  vld, ret;
        vld = (int'($urandom_range(0, 99)) < p_push);
        crv = int'($urandom_range(0, NUM_VCS - 1));
        ret = (m_cred[crv] < BUF_DEPTH) && (int'($urandom_range(0, 99)) < p_ret);
        cyc(vld, DEST_BITS'($urandom), $urandom, ret, crv);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
